// File: rtl/cla_addsub_pipe_if.sv
// Operand/result bundle for cla_addsub_pipe: valid/ready in, valid/ready out.
// The DUT side is 'slave'; the issue/writeback side is 'master'.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             in_carry;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [3:0]       out_flags;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_op, in_carry, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_flags, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_carry, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_flags, out_tag
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA add/sub (ADD/SUB/ADC/SBC) with NZCV; latency STAGES cycles, one slice per stage.
// Whole pipe freezes while out_valid && !out_ready; in_ready mirrors that advance condition.
module cla_addsub_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic            clk,
  input  logic            reset,
  cla_addsub_pipe_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;

  // Returns carries c[0..SW] of one slice; c[0] is the slice carry-in.
  function automatic logic [SW:0] cla_carries(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                              input logic ci);
    logic [SW-1:0] g, p;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic [SW:0]   c;
    logic          t, term;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    // Second level: every group carry is a flat sum-of-products of group P/G and ci.
    for (int j = 0; j <= NG; j++) begin
      t = ci;
      for (int i = 0; i < j; i++) t = t & gp[i];
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & gp[m];
        t = t | term;
      end
      gc[j] = t;
    end
    c = '0;
    for (int j = 0; j < NG; j++) begin
      for (int bi = 0; bi < 4; bi++) begin
        t = gc[j];
        for (int m = 0; m < bi; m++) t = t & p[4*j+m];
        for (int i = 0; i < bi; i++) begin
          term = g[4*j+i];
          for (int m = i + 1; m < bi; m++) term = term & p[4*j+m];
          t = t | term;
        end
        c[4*j+bi] = t;
      end
    end
    c[SW] = gc[NG];
    return c;
  endfunction

  logic             vld_r [STAGES];
  logic             c_r   [STAGES];
  logic             cm_r  [STAGES];
  logic             z_r   [STAGES];
  logic [WIDTH-1:0] s_r   [STAGES];
  logic [WIDTH-1:0] a_r   [STAGES];
  logic [WIDTH-1:0] b_r   [STAGES];
  logic [TAG_W-1:0] tag_r [STAGES];

  logic             c_nx  [STAGES];
  logic             cm_nx [STAGES];
  logic             z_nx  [STAGES];
  logic [WIDTH-1:0] s_nx  [STAGES];

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin;

  assign advance = !vld_r[STAGES-1] || bus.out_ready;
  assign b_eff   = bus.in_op[0] ? ~bus.in_b : bus.in_b;
  assign cin     = bus.in_op[1] ? bus.in_carry : bus.in_op[0];

  always_comb begin
    logic [WIDTH-1:0] a_src, b_src, s_src;
    logic             ci, z_src;
    logic [SW:0]      cv;
    logic [SW-1:0]    sl;
    for (int k = 0; k < STAGES; k++) begin
      a_src = bus.in_a;
      b_src = b_eff;
      s_src = '0;
      ci    = cin;
      z_src = 1'b1;
      if (k > 0) begin
        a_src = a_r[k-1];
        b_src = b_r[k-1];
        s_src = s_r[k-1];
        ci    = c_r[k-1];
        z_src = z_r[k-1];
      end
      cv = cla_carries(a_src[k*SW +: SW], b_src[k*SW +: SW], ci);
      sl = a_src[k*SW +: SW] ^ b_src[k*SW +: SW] ^ cv[SW-1:0];
      s_nx[k]            = s_src;
      s_nx[k][k*SW +: SW] = sl;
      c_nx[k]  = cv[SW];
      cm_nx[k] = cv[SW-1];
      z_nx[k]  = z_src & ~(|sl);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_r[k] <= 1'b0;
        c_r[k]   <= 1'b0;
        cm_r[k]  <= 1'b0;
        z_r[k]   <= 1'b0;
        s_r[k]   <= '0;
        a_r[k]   <= '0;
        b_r[k]   <= '0;
        tag_r[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        if (k == 0) begin
          vld_r[k] <= bus.in_valid;
          a_r[k]   <= bus.in_a;
          b_r[k]   <= b_eff;
          tag_r[k] <= bus.in_tag;
        end else begin
          vld_r[k] <= vld_r[k-1];
          a_r[k]   <= a_r[k-1];
          b_r[k]   <= b_r[k-1];
          tag_r[k] <= tag_r[k-1];
        end
        s_r[k]  <= s_nx[k];
        c_r[k]  <= c_nx[k];
        cm_r[k] <= cm_nx[k];
        z_r[k]  <= z_nx[k];
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_r[STAGES-1];
  assign bus.out_sum   = s_r[STAGES-1];
  assign bus.out_tag   = tag_r[STAGES-1];
  assign bus.out_flags = {s_r[STAGES-1][WIDTH-1], z_r[STAGES-1], c_r[STAGES-1],
                          c_r[STAGES-1] ^ cm_r[STAGES-1]};
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed vectors on a 64/2 instance plus random traffic on four width/stage configurations.
module tb_cla_addsub_pipe;
  localparam int NOPS = 3000;
  localparam int CW [4] = '{64, 64, 64, 32};
  localparam int CS [4] = '{1, 2, 4, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- directed instance ----------------
  logic drst;
  cla_addsub_pipe_if #(.WIDTH(64), .TAG_W(5)) dbus ();
  cla_addsub_pipe #(.WIDTH(64), .STAGES(2), .TAG_W(5)) ddut (
    .clk(clk), .reset(drst), .bus(dbus.slave)
  );

  task automatic run_one(input string name, input logic [1:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic ci, input logic [4:0] t,
                         input logic [63:0] es, input logic [3:0] ef);
    int lat;
    bit seen;
    @(negedge clk);
    dbus.out_ready = 1'b1;
    dbus.in_valid  = 1'b1;
    dbus.in_op = op; dbus.in_a = a; dbus.in_b = b; dbus.in_carry = ci; dbus.in_tag = t;
    #1 check({name, "_rdy"}, 128'(dbus.in_ready), 128'(1));
    @(negedge clk);
    dbus.in_valid = 1'b0;
    lat = 1;
    seen = 0;
    while (!seen && lat < 10) begin
      #1;
      if (dbus.out_valid) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    check({name, "_lat"}, 128'(lat), 128'(2));
    check({name, "_sum"}, 128'(dbus.out_sum), 128'(es));
    check({name, "_flg"}, 128'(dbus.out_flags), 128'(ef));
    check({name, "_tag"}, 128'(dbus.out_tag), 128'(t));
  endtask

  task automatic stall_test();
    int sent, got, cyc;
    bit held_v;
    logic [72:0] held, cur;
    logic [63:0] es;
    sent = 0; got = 0; cyc = 0; held_v = 0; held = '0;
    while (got < 6 && cyc < 40) begin
      @(negedge clk);
      dbus.out_ready = !(cyc >= 3 && cyc <= 5);
      dbus.in_valid  = (sent < 6);
      dbus.in_op = 2'b00; dbus.in_carry = 1'b0; dbus.in_tag = 5'(sent);
      dbus.in_a = 64'(sent) * 64'h0123_4567_89AB_CDEF;
      dbus.in_b = 64'hFEDC_BA98_7654_3210 + 64'(sent);
      #1;
      cur = {dbus.out_tag, dbus.out_flags, dbus.out_sum};
      if (held_v) check("stall_hold", 128'(cur), 128'(held));
      held_v = 0;
      if (dbus.out_valid && !dbus.out_ready) begin
        check("stall_rdy", 128'(dbus.in_ready), 128'(0));
        held = cur;
        held_v = 1;
      end
      if (dbus.out_valid && dbus.out_ready) begin
        es = 64'(got) * 64'h0123_4567_89AB_CDEF + 64'hFEDC_BA98_7654_3210 + 64'(got);
        check("stall_tag", 128'(dbus.out_tag), 128'(got));
        check("stall_sum", 128'(dbus.out_sum), 128'(es));
        got++;
      end
      if (dbus.in_valid && dbus.in_ready) sent++;
      cyc++;
    end
    dbus.in_valid = 1'b0;
    check("stall_count", 128'(got), 128'(6));
  endtask

  task automatic reset_test();
    int emitted;
    @(negedge clk);
    dbus.out_ready = 1'b1; dbus.in_valid = 1'b1; dbus.in_op = 2'b00;
    dbus.in_a = 64'd11; dbus.in_b = 64'd22; dbus.in_carry = 1'b0; dbus.in_tag = 5'd17;
    @(negedge clk);
    dbus.out_ready = 1'b0; dbus.in_a = 64'd33; dbus.in_tag = 5'd18;
    @(negedge clk);
    dbus.in_valid = 1'b0;
    drst = 1'b1;
    @(negedge clk);
    drst = 1'b0;
    #1;
    check("rst_vld", 128'(dbus.out_valid), 128'(0));
    check("rst_sum", 128'(dbus.out_sum), 128'(0));
    check("rst_flg", 128'(dbus.out_flags), 128'(0));
    check("rst_tag", 128'(dbus.out_tag), 128'(0));
    check("rst_rdy", 128'(dbus.in_ready), 128'(1));
    emitted = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dbus.out_ready = 1'b1;
      #1 if (dbus.out_valid) emitted++;
    end
    check("rst_discard", 128'(emitted), 128'(0));
  endtask

  initial begin
    int guard;
    drst = 1'b1;
    dbus.in_valid = 1'b0; dbus.in_a = '0; dbus.in_b = '0; dbus.in_op = 2'b00;
    dbus.in_carry = 1'b0; dbus.in_tag = '0; dbus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    drst = 1'b0;
    #1;
    check("init_vld", 128'(dbus.out_valid), 128'(0));
    check("init_rdy", 128'(dbus.in_ready), 128'(1));
    check("init_sum", 128'(dbus.out_sum), 128'(0));
    check("init_flg", 128'(dbus.out_flags), 128'(0));

    run_one("add_wrap", 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 5'd3, 64'h0, 4'b0110);
    run_one("add_ovf",  2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 5'd4,
            64'h8000_0000_0000_0000, 4'b1001);
    run_one("sub_neg",  2'b01, 64'd5, 64'd7, 1'b0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    run_one("sbc_c0",   2'b11, 64'd10, 64'd3, 1'b0, 5'd6, 64'd6, 4'b0010);
    run_one("adc_c1",   2'b10, 64'hFFFF_FFFF, 64'd0, 1'b1, 5'd7, 64'h1_0000_0000, 4'b0000);
    run_one("add_b32",  2'b00, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 5'd8,
            64'h0000_0001_0000_0000, 4'b0000);
    stall_test();
    reset_test();

    guard = 0;
    while (!(g[0].done && g[1].done && g[2].done && g[3].done) && guard < 40000) begin
      @(negedge clk);
      guard++;
    end
    check("rnd_done", 128'(g[0].done && g[1].done && g[2].done && g[3].done), 128'(1));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- randomized instances ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int W = CW[gi];
    localparam int S = CS[gi];
    logic rst;
    logic done = 1'b0;
    logic [W+8:0] q [$];

    cla_addsub_pipe_if #(.WIDTH(W), .TAG_W(5)) bus ();
    cla_addsub_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(5)) dut (
      .clk(clk), .reset(rst), .bus(bus.slave)
    );

    function automatic logic [W+8:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic ci,
                                           input logic [4:0] t);
      logic [W-1:0] be, s;
      logic [W:0]   full;
      logic         c0, v;
      be   = op[0] ? ~b : b;
      c0   = op[1] ? ci : op[0];
      full = {1'b0, a} + {1'b0, be} + (W+1)'(c0);
      s    = full[W-1:0];
      v    = (a[W-1] == be[W-1]) && (s[W-1] != a[W-1]);
      return {t, s[W-1], (s == '0), full[W], v, s};
    endfunction

    function automatic logic [W-1:0] pick();
      logic [W-1:0] r;
      r = W'({$urandom, $urandom});
      case ($urandom_range(0, 7))
        0: r = '0;
        1: r = '1;
        2: r = {1'b0, {(W-1){1'b1}}};
        3: r = {1'b1, {(W-1){1'b0}}};
        default: ;
      endcase
      return r;
    endfunction

    initial begin
      int sent, got, cyc;
      logic [4:0] tg;
      logic [W+8:0] exp_v;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 2'b00;
      bus.in_carry = 1'b0; bus.in_tag = '0; bus.out_ready = 1'b0;
      sent = 0; got = 0; cyc = 0; tg = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      while (got < NOPS && cyc < NOPS * 8) begin
        @(negedge clk);
        cyc++;
        bus.out_ready = ($urandom_range(0, 3) != 0);
        bus.in_valid  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
        bus.in_op     = 2'($urandom_range(0, 3));
        bus.in_a      = pick();
        bus.in_b      = pick();
        bus.in_carry  = 1'($urandom_range(0, 1));
        bus.in_tag    = tg;
        #1;
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) check($sformatf("rnd%0d_spurious", gi), 128'(1), 128'(0));
          else begin
            exp_v = q.pop_front();
            check($sformatf("rnd%0d_res", gi),
                  128'({bus.out_tag, bus.out_flags, bus.out_sum}), 128'(exp_v));
          end
          got++;
        end
        if (bus.in_valid && bus.in_ready) begin
          q.push_back(model(bus.in_op, bus.in_a, bus.in_b, bus.in_carry, tg));
          tg = tg + 5'd1;
          sent++;
        end
      end
      bus.in_valid = 1'b0;
      check($sformatf("rnd%0d_count", gi), 128'(got), 128'(NOPS));
      done = 1'b1;
    end
  end
endmodule
